// File: rtl/sro_result_collector_if.sv
// ---------------------------------------------------------------------------
// sro_result_collector_if
// Bundles the signals exchanged between an SRO result collector and its
// surroundings: the snooped datapath controls/outputs, the host-side record
// drain port (valid/ready) and the status outputs.
//
//   slave  modport : the collector (consumes datapath signals and rec_ready,
//                    produces records and status)
//   master modport : the datapath/host side (drives start, seed, datapath
//                    outputs and rec_ready; observes records and status)
// ---------------------------------------------------------------------------
interface sro_result_collector_if #(
    parameter int RULES = 32
);
    // Datapath snoop
    logic             start;
    logic [63:0]      seed;
    logic [RULES-1:0] network_state;
    logic             steady_state;
    logic [9:0]       round_number;

    // Record drain port
    logic             rec_valid;
    logic             rec_ready;
    logic [63:0]      rec_seed;
    logic [RULES-1:0] rec_state;
    logic             rec_ss;
    logic [9:0]       rec_ss_round;

    // Status
    logic             busy;
    logic [11:0]      run_count;
    logic [7:0]       abort_count;
    logic             overflow;

    modport slave (
        input  start, seed, network_state, steady_state, round_number,
        input  rec_ready,
        output rec_valid, rec_seed, rec_state, rec_ss, rec_ss_round,
        output busy, run_count, abort_count, overflow
    );

    modport master (
        output start, seed, network_state, steady_state, round_number,
        output rec_ready,
        input  rec_valid, rec_seed, rec_state, rec_ss, rec_ss_round,
        input  busy, run_count, abort_count, overflow
    );
endinterface

// File: rtl/sro_result_collector.sv
// ---------------------------------------------------------------------------
// sro_result_collector
// Snoops one SRO datapath and captures a result record for every completed
// run: {seed, final network_state, steady_state flag, first steady round}.
// Records are queued in a small FIFO and drained by a host over valid/ready.
//
// Ports:
//   clk  - single rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - sro_result_collector_if.slave
//          in : start, seed, network_state, steady_state, round_number,
//               rec_ready
//          out: rec_valid, rec_seed, rec_state, rec_ss, rec_ss_round,
//               busy, run_count, abort_count, overflow
// ---------------------------------------------------------------------------
module sro_result_collector #(
    parameter int RULES        = 32,
    parameter int ROUND_NUMBER = 1000,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    sro_result_collector_if.slave   bus
);
    localparam int         AW        = $clog2(FIFO_DEPTH);
    localparam int         PW        = AW + 1;
    localparam logic [9:0] ROUND_END = 10'(ROUND_NUMBER);
    localparam logic [9:0] SS_NONE   = 10'h3FF;
    localparam logic [PW-1:0] DEPTH_P = PW'(FIFO_DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    // Run tracking
    state_t      state_reg;
    logic [63:0] seed_reg;
    logic        ss_seen_reg;
    logic [9:0]  ss_round_reg;
    logic [11:0] run_count_reg;
    logic [7:0]  abort_count_reg;
    logic        overflow_reg;

    // Record FIFO
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW-1:0]    count_reg;
    logic [63:0]      seed_mem     [FIFO_DEPTH];
    logic [RULES-1:0] state_mem    [FIFO_DEPTH];
    logic             ss_mem       [FIFO_DEPTH];
    logic [9:0]       ss_round_mem [FIFO_DEPTH];

    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    assign wr_idx = wr_ptr_reg[AW-1:0];
    assign rd_idx = rd_ptr_reg[AW-1:0];

    logic       restart;
    logic       ss_first;
    logic       complete;
    logic [9:0] rec_round_next;
    logic       pop;
    logic       full;
    logic       push;
    logic       drop;

    always_comb begin
        restart        = (state_reg == RUN) && bus.start;
        ss_first       = (state_reg == RUN) && !bus.start && bus.steady_state && !ss_seen_reg;
        complete       = (state_reg == RUN) && !bus.start && (bus.round_number == ROUND_END);
        // A first steady sighting on the completion edge itself must land in
        // the record, so bypass the not-yet-updated ss_round_reg.
        rec_round_next = ss_first ? bus.round_number : ss_round_reg;
        pop            = (count_reg != '0) && bus.rec_ready;
        full           = (count_reg == DEPTH_P);
        // A full FIFO still accepts the push when the head leaves on the same edge.
        push           = complete && (!full || pop);
        drop           = complete && !push;
    end

    // Run-tracking FSM and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            seed_reg        <= '0;
            ss_seen_reg     <= 1'b0;
            ss_round_reg    <= SS_NONE;
            run_count_reg   <= '0;
            abort_count_reg <= '0;
            overflow_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        seed_reg     <= bus.seed;
                        ss_seen_reg  <= 1'b0;
                        ss_round_reg <= SS_NONE;
                        state_reg    <= RUN;
                    end
                end
                RUN: begin
                    if (restart) begin
                        // Restart wins over completion: discard and re-arm.
                        seed_reg     <= bus.seed;
                        ss_seen_reg  <= 1'b0;
                        ss_round_reg <= SS_NONE;
                        if (abort_count_reg != 8'hFF) begin
                            abort_count_reg <= abort_count_reg + 8'd1;
                        end
                    end else begin
                        if (ss_first) begin
                            ss_round_reg <= bus.round_number;
                            ss_seen_reg  <= 1'b1;
                        end
                        if (complete) begin
                            state_reg     <= IDLE;
                            run_count_reg <= run_count_reg + 12'd1;
                            if (drop) begin
                                overflow_reg <= 1'b1;
                            end
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // FIFO pointers and occupancy; pointers keep their MSB at zero so they
    // wrap modulo the depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= {1'b0, wr_idx + AW'(1)};
            end
            if (pop) begin
                rd_ptr_reg <= {1'b0, rd_idx + AW'(1)};
            end
            count_reg <= count_reg + PW'(push) - PW'(pop);
        end
    end

    // Record storage; cleared on reset so no stale record survives it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                seed_mem[i]     <= '0;
                state_mem[i]    <= '0;
                ss_mem[i]       <= 1'b0;
                ss_round_mem[i] <= SS_NONE;
            end
        end else if (push) begin
            seed_mem[wr_idx]     <= seed_reg;
            state_mem[wr_idx]    <= bus.network_state;
            ss_mem[wr_idx]       <= bus.steady_state;
            ss_round_mem[wr_idx] <= rec_round_next;
        end
    end

    // Outputs come straight from registers / the head slot.
    assign bus.rec_valid    = (count_reg != '0);
    assign bus.rec_seed     = seed_mem[rd_idx];
    assign bus.rec_state    = state_mem[rd_idx];
    assign bus.rec_ss       = ss_mem[rd_idx];
    assign bus.rec_ss_round = ss_round_mem[rd_idx];
    assign bus.busy         = (state_reg == RUN);
    assign bus.run_count    = run_count_reg;
    assign bus.abort_count  = abort_count_reg;
    assign bus.overflow     = overflow_reg;

endmodule

// File: tb/tb_sro_result_collector.sv
// ---------------------------------------------------------------------------
// tb_sro_result_collector
// Directed self-checking bench for sro_result_collector with RULES=4,
// ROUND_NUMBER=8, FIFO_DEPTH=2. Inputs change on the falling edge and outputs
// are checked on the falling edge, half a cycle away from the active edge.
// ---------------------------------------------------------------------------
module tb_sro_result_collector;
    localparam int RULES = 4;
    localparam int NEVER = 15;   // steady-state never asserted

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    sro_result_collector_if #(.RULES(RULES)) bus ();

    sro_result_collector #(
        .RULES        (RULES),
        .ROUND_NUMBER (8),
        .FIFO_DEPTH   (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("vec %0d %s: observed %0h expected %0h", vectors, tag, obs, exp);
    endtask

    // Called at a falling edge: one-cycle start pulse.
    task automatic start_run(input logic [63:0] s);
        bus.start        = 1'b1;
        bus.seed         = s;
        bus.round_number = 10'd0;
        bus.steady_state = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Present rounds lo..hi, one per cycle; steady from round ss_from;
    // network_state becomes fs on round 8.
    task automatic ramp(input int lo, input int hi, input int ss_from, input logic [3:0] fs);
        for (int r = lo; r <= hi; r++) begin
            bus.round_number  = 10'(r);
            bus.steady_state  = (r >= ss_from);
            bus.network_state = (r == 8) ? fs : 4'(r);
            @(negedge clk);
        end
    endtask

    task automatic full_run(input logic [63:0] s, input int ss_from, input logic [3:0] fs);
        start_run(s);
        ramp(0, 8, ss_from, fs);
    endtask

    initial begin
        vectors          = 0;
        miscompares      = 0;
        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.seed         = '0;
        bus.network_state = '0;
        bus.steady_state = 1'b0;
        bus.round_number = '0;
        bus.rec_ready    = 1'b0;

        // ---- Reset state ----
        repeat (2) @(negedge clk);
        chk("rst_valid",    64'(bus.rec_valid), 64'd0);
        chk("rst_busy",     64'(bus.busy), 64'd0);
        chk("rst_runcnt",   64'(bus.run_count), 64'd0);
        chk("rst_abort",    64'(bus.abort_count), 64'd0);
        chk("rst_ovf",      64'(bus.overflow), 64'd0);
        chk("rst_ssround",  64'(bus.rec_ss_round), 64'h3FF);
        chk("rst_seed",     bus.rec_seed, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // ---- 1: basic run ----
        bus.rec_ready = 1'b1;
        start_run(64'hA5);
        chk("s1_busy_up", 64'(bus.busy), 64'd1);
        ramp(0, 7, 5, 4'b1010);
        chk("s1_valid_pre", 64'(bus.rec_valid), 64'd0);
        ramp(8, 8, 5, 4'b1010);
        chk("s1_valid",   64'(bus.rec_valid), 64'd1);
        chk("s1_seed",    bus.rec_seed, 64'hA5);
        chk("s1_state",   64'(bus.rec_state), 64'hA);
        chk("s1_ss",      64'(bus.rec_ss), 64'd1);
        chk("s1_ssround", 64'(bus.rec_ss_round), 64'd5);
        chk("s1_runcnt",  64'(bus.run_count), 64'd1);
        chk("s1_busy_dn", 64'(bus.busy), 64'd0);
        @(negedge clk);
        chk("s1_drained", 64'(bus.rec_valid), 64'd0);

        // ---- 2: no steady state ----
        bus.rec_ready = 1'b0;
        full_run(64'hB, NEVER, 4'b0110);
        chk("s2_seed",    bus.rec_seed, 64'hB);
        chk("s2_state",   64'(bus.rec_state), 64'h6);
        chk("s2_ss",      64'(bus.rec_ss), 64'd0);
        chk("s2_ssround", 64'(bus.rec_ss_round), 64'h3FF);
        bus.rec_ready = 1'b1;
        @(negedge clk);
        bus.rec_ready = 1'b0;
        chk("s2_drained", 64'(bus.rec_valid), 64'd0);

        // ---- 3: overflow ----
        full_run(64'd1, NEVER, 4'h1);
        full_run(64'd2, NEVER, 4'h2);
        chk("s3_head_hold", bus.rec_seed, 64'd1);
        chk("s3_ovf_pre",   64'(bus.overflow), 64'd0);
        full_run(64'd3, NEVER, 4'h3);
        chk("s3_ovf",     64'(bus.overflow), 64'd1);
        chk("s3_runcnt",  64'(bus.run_count), 64'd5);
        chk("s3_head1",   bus.rec_seed, 64'd1);
        bus.rec_ready = 1'b1;
        @(negedge clk);
        chk("s3_valid2",  64'(bus.rec_valid), 64'd1);
        chk("s3_head2",   bus.rec_seed, 64'd2);
        @(negedge clk);
        chk("s3_empty",   64'(bus.rec_valid), 64'd0);
        bus.rec_ready = 1'b0;

        // ---- 4: full FIFO with simultaneous pop ----
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("s4_ovf_clr", 64'(bus.overflow), 64'd0);
        full_run(64'd1, NEVER, 4'h1);
        full_run(64'd2, NEVER, 4'h2);
        start_run(64'd3);
        ramp(0, 7, NEVER, 4'h3);
        bus.rec_ready = 1'b1;
        ramp(8, 8, NEVER, 4'h3);
        bus.rec_ready = 1'b0;
        chk("s4_ovf",    64'(bus.overflow), 64'd0);
        chk("s4_runcnt", 64'(bus.run_count), 64'd3);
        chk("s4_head2",  bus.rec_seed, 64'd2);
        bus.rec_ready = 1'b1;
        @(negedge clk);
        chk("s4_valid3", 64'(bus.rec_valid), 64'd1);
        chk("s4_head3",  bus.rec_seed, 64'd3);
        chk("s4_state3", 64'(bus.rec_state), 64'h3);
        @(negedge clk);
        chk("s4_empty",  64'(bus.rec_valid), 64'd0);
        bus.rec_ready = 1'b0;

        // ---- 5: restart (final run sees steady only on the completion edge) ----
        start_run(64'd7);
        ramp(0, 3, NEVER, 4'h0);
        bus.start        = 1'b1;
        bus.seed         = 64'd9;
        bus.round_number = 10'd4;
        @(negedge clk);
        bus.start = 1'b0;
        chk("s5_abort",     64'(bus.abort_count), 64'd1);
        chk("s5_busy",      64'(bus.busy), 64'd1);
        chk("s5_novalid",   64'(bus.rec_valid), 64'd0);
        ramp(0, 8, 8, 4'b0101);
        chk("s5_seed",      bus.rec_seed, 64'd9);
        chk("s5_runcnt",    64'(bus.run_count), 64'd4);
        chk("s5_ss",        64'(bus.rec_ss), 64'd1);
        chk("s5_ssround",   64'(bus.rec_ss_round), 64'd8);
        bus.rec_ready = 1'b1;
        @(negedge clk);
        bus.rec_ready = 1'b0;
        chk("s5_single",    64'(bus.rec_valid), 64'd0);

        // ---- 6: asynchronous reset mid-operation ----
        full_run(64'h55, NEVER, 4'h5);
        chk("s6_pending", 64'(bus.rec_valid), 64'd1);
        start_run(64'h66);
        ramp(0, 2, NEVER, 4'h0);
        bus.round_number = 10'd3;
        #2 rst = 1'b1;
        #1;
        chk("s6_valid",   64'(bus.rec_valid), 64'd0);
        chk("s6_busy",    64'(bus.busy), 64'd0);
        chk("s6_runcnt",  64'(bus.run_count), 64'd0);
        chk("s6_abort",   64'(bus.abort_count), 64'd0);
        chk("s6_ssround", 64'(bus.rec_ss_round), 64'h3FF);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus.rec_ready = 1'b1;
        full_run(64'hA5, 5, 4'b1010);
        chk("s6_r_valid",   64'(bus.rec_valid), 64'd1);
        chk("s6_r_seed",    bus.rec_seed, 64'hA5);
        chk("s6_r_state",   64'(bus.rec_state), 64'hA);
        chk("s6_r_ssround", 64'(bus.rec_ss_round), 64'd5);
        chk("s6_r_runcnt",  64'(bus.run_count), 64'd1);
        @(negedge clk);
        chk("s6_r_drained", 64'(bus.rec_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sro_result_collector.md
# sro_result_collector

Hardware receiver for the SRO run protocol. It snoops the controls and outputs of one SRO datapath: the `start` pulse, the `seed`, `network_state`, `steady_state` and `round_number`. For each completed run it captures one result record: the seed, the final network state, the steady-state flag and the first steady-state round. Records go into a small FIFO, which a host drains through a valid/ready port. The block sits beside the datapath and makes per-seed sweep results observable without a simulator.

## Interface
- `RULES`, 32: width of `network_state`.
- `ROUND_NUMBER`, 1000: round count at which a run is complete; must be less than 1023.
- `FIFO_DEPTH`, 4: number of record slots; power of two, at least 2.
- `clk` in 1: the single clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: run-start pulse, the same signal that drives the datapath.
- `seed` in 64: seed of the run; sampled when `start` is sampled high.
- `network_state` in RULES: datapath network state.
- `steady_state` in 1: datapath steady-state flag.
- `round_number` in 10: datapath round counter.
- `rec_valid` out 1: the FIFO head holds a record.
- `rec_ready` in 1: the host accepts the head record.
- `rec_seed` out 64: head record, seed.
- `rec_state` out RULES: head record, final `network_state`.
- `rec_ss` out 1: head record, `steady_state` at completion.
- `rec_ss_round` out 10: head record, first round at which `steady_state` was sampled high; `10'h3FF` if never.
- `busy` out 1: a run is being tracked (state RUN).
- `run_count` out 12: completed runs; wraps at 4096.
- `abort_count` out 8: runs restarted before completion; saturates at 255.
- `overflow` out 1: sticky; set when a record is dropped because the FIFO is full.

## Operation
- The FSM has two states, IDLE and RUN.
- **IDLE, `start` sampled high:**
  - latch `seed`;
  - clear `ss_seen`;
  - set `ss_round` to `10'h3FF`;
  - go to RUN.
- **IDLE, `start` low:** all other inputs are ignored.
- **RUN, each edge with `start` low:**
  - if `steady_state` is 1 and `ss_seen` is 0, then `ss_round <= round_number` and `ss_seen <= 1`;
  - if `round_number == ROUND_NUMBER`, the run completes (see below) and the FSM returns to IDLE.
- **Completion:**
  - the record written is {latched seed, `network_state`, `steady_state`, `ss_round`};
  - if the first steady-state sighting happens on the completion edge itself, the record carries that edge's `round_number` as `rec_ss_round`;
  - `run_count` increments.
- **RUN, `start` sampled high (restart):**
  - the current run is discarded and no record is written;
  - `abort_count` increments;
  - the new seed is latched and the per-run fields are cleared;
  - the FSM stays in RUN;
  - this takes priority over completion on the same edge.
- **FIFO:**
  - read pointer, write pointer and count registers of width `$clog2(FIFO_DEPTH)+1`; pointers wrap modulo `FIFO_DEPTH`;
  - the head is popped on an edge where `rec_valid` and `rec_ready` are both 1;
  - a push is accepted if the FIFO is not full, or if it is full and a pop occurs on the same edge;
  - otherwise the record is dropped, `overflow` is set, and `run_count` still increments;
  - simultaneous push and pop leaves the count unchanged.
- **`rec_*` data:** driven from the head slot. Values are don't-care while `rec_valid` is 0, but must hold stable while `rec_valid` is 1 and `rec_ready` is 0.
- **Reset:** asserting `rst` at any time, including mid-run or with a full FIFO:
  - forces IDLE and an empty FIFO;
  - forces `rec_valid`=0, `busy`=0, `run_count`=0, `abort_count`=0, `overflow`=0;
  - clears all stored records.
- **Reset values:** all outputs are 0 during and after reset, except `rec_ss_round`, which is `10'h3FF`.

## Timing
- The FSM, counters and FIFO are all registered; there are no combinational paths from inputs to `rec_valid` or `busy`.
- `busy` goes high the cycle after the edge at which `start` is sampled, and low the cycle after the completion edge.
- **Record latency:** the record written at completion edge E is visible, with `rec_valid`=1, from E+1 if the FIFO was empty. Otherwise it appears after the records ahead of it are popped.
- **Throughput:** one record per cycle pushed and one per cycle popped.
- `rec_ready` is sampled only at the rising edge.
- `start` is treated as a level sampled each edge. A 2-cycle pulse therefore counts as start followed by a restart, so callers issue 1-cycle pulses.

## Test plan
Settings for all scenarios: `RULES`=4, `ROUND_NUMBER`=8, `FIFO_DEPTH`=2.
1. **Basic run:**
   - stimulus: reset, then `start` for 1 cycle with `seed`=64'hA5; ramp `round_number` 0→8; assert `steady_state` from round 5; final state 4'b1010; `rec_ready`=1;
   - response: exactly one record, `rec_seed`=64'hA5, `rec_state`=1010, `rec_ss`=1, `rec_ss_round`=5; `run_count`=1; `rec_valid` high 1 cycle after round 8 is sampled.
2. **No steady state:**
   - stimulus: same run with `steady_state` held 0;
   - response: `rec_ss`=0, `rec_ss_round`=10'h3FF.
3. **Overflow:**
   - stimulus: `rec_ready`=0; three back-to-back runs with seeds 1, 2, 3;
   - response: records 1 and 2 are retained and `overflow`=1 after the third completion; `run_count`=3; draining yields seeds 1 then 2, then `rec_valid`=0.
4. **Full FIFO with simultaneous pop:**
   - stimulus: FIFO full with seeds 1 and 2; a third run completes on the same edge that `rec_ready` pops seed 1;
   - response: no overflow; FIFO holds seeds 2 then 3.
5. **Restart:**
   - stimulus: `start` with seed 7; at round 4, `start` with seed 9; run to round 8;
   - response: one record, `rec_seed`=9; `abort_count`=1; `run_count`=1.
6. **Reset mid-operation:**
   - stimulus: assert `rst` asynchronously (off-edge) at round 3 with one record pending;
   - response: immediately `rec_valid`=0, `busy`=0, all counters 0; after release, the next run behaves as in scenario 1.
